// File: rtl/ni_packetizer.sv
// ni_packetizer: NI transmitter turning PE message requests into a
// head/body/tail flit stream with per-VC credit flow control.
// Optional build macro PKTZ_STATS_EN adds pkt_sent_cnt and stall_cnt outputs.
//
// Handshakes: a transfer happens in a cycle where valid and ready are both
// high at the rising edge; valid never depends on ready, and ready may be
// raised or lowered by the block without regard to valid.
module ni_packetizer #(
   parameter int BUF_DEPTH    = 4,
   parameter int MAX_LEN      = 16,
   parameter int PKT_ID_START = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  curr_x,
   input  logic [2:0]  curr_y,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_dest_x,
   input  logic [2:0]  req_dest_y,
   input  logic [5:0]  req_len,
   input  logic        data_valid,
   output logic        data_ready,
   input  logic [47:0] data_in,
   input  logic [1:0]  credit_return,
   output logic [63:0] flit_out,
   output logic        flit_valid,
   output logic [1:0]  flit_vc,
   output logic        busy,
   output logic        err_len,
   output logic        credit_err
`ifdef PKTZ_STATS_EN
   ,
   output logic [15:0] pkt_sent_cnt,
   output logic [15:0] stall_cnt
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HEAD = 2'd1,
      DATA = 2'd2
   } state_t;

   localparam logic [3:0] CREDIT_MAX = 4'(BUF_DEPTH);
   localparam logic [5:0] LEN_MAX    = 6'(MAX_LEN);
   localparam logic [6:0] ID_START   = 7'(PKT_ID_START);

   state_t     state;
   state_t     state_next;

   logic [3:0] credit0;
   logic [3:0] credit1;
   logic [2:0] dest_x_q;
   logic [2:0] dest_y_q;
   logic [5:0] len_q;
   logic [5:0] word_idx;      // index (1-based) of the next payload word
   logic [6:0] pkt_id;
   logic       vc_q;          // VC locked for the packet in flight

   logic       len_ok;
   logic       req_fire;
   logic       head_fire;
   logic       head_vc;
   logic       data_fire;
   logic       tail_fire;
   logic       vc_has_credit;
   logic       sent0;
   logic       sent1;

   // Credit arithmetic: send consumes, return restores, both cancel; a
   // return into a full counter saturates (the caller flags the overflow).
   function automatic logic [3:0] credit_next(input logic [3:0] cnt,
                                              input logic       sent,
                                              input logic       ret);
      logic [3:0] nxt;
      nxt = cnt;
      if (sent && !ret) begin
         nxt = cnt - 4'd1;
      end else if (!sent && ret && (cnt != CREDIT_MAX)) begin
         nxt = cnt + 4'd1;
      end
      return nxt;
   endfunction

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FSM next-state and handshake/fire decode
   always_comb begin
      state_next    = state;
      req_ready     = 1'b0;
      data_ready    = 1'b0;
      busy          = 1'b0;
      req_fire      = 1'b0;
      head_fire     = 1'b0;
      head_vc       = 1'b0;
      data_fire     = 1'b0;
      tail_fire     = 1'b0;
      len_ok        = (req_len != 6'd0) && (req_len <= LEN_MAX);
      vc_has_credit = vc_q ? (credit1 != 4'd0) : (credit0 != 4'd0);
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            req_fire  = req_valid;
            if (req_valid && len_ok) begin
               state_next = HEAD;
            end
         end
         HEAD: begin
            busy = 1'b1;
            // VC0 preferred; VC1 only when VC0 has no space
            if (credit0 != 4'd0) begin
               head_fire  = 1'b1;
               head_vc    = 1'b0;
               state_next = DATA;
            end else if (credit1 != 4'd0) begin
               head_fire  = 1'b1;
               head_vc    = 1'b1;
               state_next = DATA;
            end
         end
         DATA: begin
            busy       = 1'b1;
            data_ready = vc_has_credit;
            if (data_valid && vc_has_credit) begin
               data_fire = 1'b1;
               if (word_idx == len_q) begin
                  tail_fire  = 1'b1;
                  state_next = IDLE;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign sent0 = (head_fire && !head_vc) || (data_fire && !vc_q);
   assign sent1 = (head_fire &&  head_vc) || (data_fire &&  vc_q);

   // Per-VC credit counters and overflow pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         credit0    <= CREDIT_MAX;
         credit1    <= CREDIT_MAX;
         credit_err <= 1'b0;
      end else begin
         credit0    <= credit_next(credit0, sent0, credit_return[0]);
         credit1    <= credit_next(credit1, sent1, credit_return[1]);
         credit_err <= (credit_return[0] && !sent0 && (credit0 == CREDIT_MAX)) ||
                       (credit_return[1] && !sent1 && (credit1 == CREDIT_MAX));
      end
   end

   // Request latch, flit assembly and packet ID sequencing
   always_ff @(posedge clk) begin
      if (rst) begin
         flit_out   <= 64'd0;
         flit_valid <= 1'b0;
         flit_vc    <= 2'b00;
         err_len    <= 1'b0;
         pkt_id     <= ID_START;
         dest_x_q   <= 3'd0;
         dest_y_q   <= 3'd0;
         len_q      <= 6'd0;
         word_idx   <= 6'd0;
         vc_q       <= 1'b0;
      end else begin
         flit_valid <= head_fire || data_fire;
         err_len    <= req_fire && !len_ok;
         if (req_fire && len_ok) begin
            dest_x_q <= req_dest_x;
            dest_y_q <= req_dest_y;
            len_q    <= req_len;
            word_idx <= 6'd1;
         end
         if (head_fire) begin
            vc_q     <= head_vc;
            flit_vc  <= {1'b0, head_vc};
            flit_out <= {dest_y_q, dest_x_q, 3'b000, pkt_id,
                         curr_y, curr_x, len_q, 36'd0};
         end
         if (data_fire) begin
            flit_vc  <= {1'b0, vc_q};
            flit_out <= {dest_y_q, dest_x_q, (tail_fire ? 3'b010 : 3'b001),
                         pkt_id, data_in};
            word_idx <= word_idx + 6'd1;
         end
         // ID 0 is skipped so a head to (0,0) is never an all-zero word
         if (tail_fire) begin
            pkt_id <= (pkt_id == 7'd127) ? 7'd1 : (pkt_id + 7'd1);
         end
      end
   end

`ifdef PKTZ_STATS_EN
   logic stall_now;
   assign stall_now = ((state == HEAD) && (credit0 == 4'd0) && (credit1 == 4'd0)) ||
                      ((state == DATA) && !vc_has_credit);

   // Packet and credit-stall statistics
   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_sent_cnt <= 16'd0;
         stall_cnt    <= 16'd0;
      end else begin
         if (tail_fire) begin
            pkt_sent_cnt <= pkt_sent_cnt + 16'd1;
         end
         if (stall_now && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_ni_packetizer.sv
// tb_ni_packetizer: directed, table-driven bench for ni_packetizer
// (default parameters BUF_DEPTH=4, MAX_LEN=16, PKT_ID_START=1).
module tb_ni_packetizer;

   logic        clk;
   logic        rst;
   logic [2:0]  curr_x;
   logic [2:0]  curr_y;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_dest_x;
   logic [2:0]  req_dest_y;
   logic [5:0]  req_len;
   logic        data_valid;
   logic        data_ready;
   logic [47:0] data_in;
   logic [1:0]  credit_return;
   logic [63:0] flit_out;
   logic        flit_valid;
   logic [1:0]  flit_vc;
   logic        busy;
   logic        err_len;
   logic        credit_err;
`ifdef PKTZ_STATS_EN
   logic [15:0] pkt_sent_cnt;
   logic [15:0] stall_cnt;
`endif

   int errors = 0;
   int checks = 0;

   logic [63:0] exp_q[$];

   typedef struct packed {
      logic        rv;
      logic [2:0]  dx;
      logic [2:0]  dy;
      logic [5:0]  len;
      logic        dv;
      logic [47:0] data;
      logic [1:0]  cr;
      logic        e_rr;
      logic        e_dr;
      logic        e_busy;
      logic        e_fv;
      logic [63:0] e_flit;
      logic [1:0]  e_vc;
      logic        e_el;
      logic        e_ce;
   } vec_t;

   vec_t vecs[$];

   ni_packetizer #(
      .BUF_DEPTH    (4),
      .MAX_LEN      (16),
      .PKT_ID_START (1)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .curr_x        (curr_x),
      .curr_y        (curr_y),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_dest_x    (req_dest_x),
      .req_dest_y    (req_dest_y),
      .req_len       (req_len),
      .data_valid    (data_valid),
      .data_ready    (data_ready),
      .data_in       (data_in),
      .credit_return (credit_return),
      .flit_out      (flit_out),
      .flit_valid    (flit_valid),
      .flit_vc       (flit_vc),
      .busy          (busy),
      .err_len       (err_len),
      .credit_err    (credit_err)
`ifdef PKTZ_STATS_EN
      ,
      .pkt_sent_cnt  (pkt_sent_cnt),
      .stall_cnt     (stall_cnt)
`endif
   );

   // Clock and watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1);
   end

   // ---------------- helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Compare the current flit against the head of the expected queue
   task automatic chk_flit_q(input string name);
      logic [63:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: got flit %h with no flit expected", name, flit_out);
      end else begin
         e = exp_q.pop_front();
         if (flit_valid !== 1'b1 || flit_out !== e || flit_vc !== 2'b00) begin
            errors++;
            $display("FAIL %s: got valid=%b flit=%h vc=%b expected valid=1 flit=%h vc=00",
                     name, flit_valid, flit_out, flit_vc, e);
         end
      end
   endtask

   function automatic logic [63:0] mk_flit(input logic [2:0] dy, input logic [2:0] dx,
                                           input logic [2:0] typ, input logic [6:0] id,
                                           input logic [47:0] pl);
      return {dy, dx, typ, id, pl};
   endfunction

   function automatic logic [47:0] mk_head_pl(input logic [2:0] cy, input logic [2:0] cx,
                                              input logic [5:0] len);
      return {cy, cx, len, 36'd0};
   endfunction

   task automatic idle_inputs();
      req_valid     = 1'b0;
      req_dest_x    = 3'd0;
      req_dest_y    = 3'd0;
      req_len       = 6'd0;
      data_valid    = 1'b0;
      data_in       = 48'd0;
      credit_return = 2'b00;
   endtask

   task automatic add_vec(input logic rv, input logic [2:0] dx, input logic [2:0] dy,
                          input logic [5:0] len, input logic dv, input logic [47:0] data,
                          input logic [1:0] cr, input logic e_rr, input logic e_dr,
                          input logic e_busy, input logic e_fv, input logic [63:0] e_flit,
                          input logic [1:0] e_vc, input logic e_el, input logic e_ce);
      vec_t v;
      v = {rv, dx, dy, len, dv, data, cr, e_rr, e_dr, e_busy, e_fv, e_flit, e_vc, e_el, e_ce};
      vecs.push_back(v);
   endtask

   // One len-1 packet on VC0, returning a credit alongside every send
   task automatic send_short(input logic [6:0] id, input logic [47:0] w);
      req_valid  = 1'b1;
      req_dest_x = id[2:0];
      req_dest_y = id[5:3];
      req_len    = 6'd1;
      step();
      req_valid     = 1'b0;
      credit_return = 2'b01;
      step();
      chk64("wrap_head", flit_out,
            mk_flit(id[5:3], id[2:0], 3'b000, id, mk_head_pl(curr_y, curr_x, 6'd1)));
      data_valid = 1'b1;
      data_in    = w;
      step();
      chk64("wrap_tail", flit_out, mk_flit(id[5:3], id[2:0], 3'b010, id, w));
      idle_inputs();
   endtask

   // ---------------- main test ----------------
   initial begin
      logic [47:0] w;
      rst    = 1'b1;
      curr_x = 3'd0;
      curr_y = 3'd0;
      idle_inputs();

      // Reset
      repeat (3) step();
      rst = 1'b0;
      chk1("rst_flit_valid", flit_valid, 1'b0);
      chk1("rst_req_ready", req_ready, 1'b1);
      chk1("rst_busy", busy, 1'b0);
      chk64("rst_flit_out", flit_out, 64'd0);
      chk1("rst_err_len", err_len, 1'b0);
      chk1("rst_credit_err", credit_err, 1'b0);

      // Table: rv dx dy len dv data cr | rr dr busy fv flit vc el ce
      // packet id 1 to (2,1) len 3 on VC0, no returns: uses all 4 credits
      add_vec(1'b1, 3'd2, 3'd1, 6'd3, 1'b0, 48'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 2'b00, 1'b0, 1'b0);
      add_vec(1'b0, 3'd0, 3'd0, 6'd0, 1'b0, 48'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 64'h2801_0030_0000_0000, 2'b00, 1'b0, 1'b0);
      add_vec(1'b0, 3'd0, 3'd0, 6'd0, 1'b1, 48'hA0A0_0000_000A, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 64'h2881_A0A0_0000_000A, 2'b00, 1'b0, 1'b0);
      add_vec(1'b0, 3'd0, 3'd0, 6'd0, 1'b1, 48'hB0B0_0000_000B, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 64'h2881_B0B0_0000_000B, 2'b00, 1'b0, 1'b0);
      add_vec(1'b0, 3'd0, 3'd0, 6'd0, 1'b1, 48'hC0C0_0000_000C, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 64'h2901_C0C0_0000_000C, 2'b00, 1'b0, 1'b0);
      add_vec(1'b0, 3'd0, 3'd0, 6'd0, 1'b0, 48'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 2'b00, 1'b0, 1'b0);
      // packet id 2 to (5,3) len 2: VC0 empty so it goes on VC1; VC0 credit back in last cycle
      add_vec(1'b1, 3'd5, 3'd3, 6'd2, 1'b0, 48'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 2'b00, 1'b0, 1'b0);
      add_vec(1'b0, 3'd0, 3'd0, 6'd0, 1'b0, 48'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 64'h7402_0020_0000_0000, 2'b01, 1'b0, 1'b0);
      add_vec(1'b0, 3'd0, 3'd0, 6'd0, 1'b1, 48'hD0D0_0000_000D, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 64'h7482_D0D0_0000_000D, 2'b01, 1'b0, 1'b0);
      add_vec(1'b0, 3'd0, 3'd0, 6'd0, 1'b1, 48'hE0E0_0000_000E, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 64'h7502_E0E0_0000_000E, 2'b01, 1'b0, 1'b0);
      // refill both VCs (1,1 -> 4,4), then overflow each VC once
      add_vec(1'b0, 3'd0, 3'd0, 6'd0, 1'b0, 48'd0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 2'b00, 1'b0, 1'b0);
      add_vec(1'b0, 3'd0, 3'd0, 6'd0, 1'b0, 48'd0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 2'b00, 1'b0, 1'b0);
      add_vec(1'b0, 3'd0, 3'd0, 6'd0, 1'b0, 48'd0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 2'b00, 1'b0, 1'b0);
      add_vec(1'b0, 3'd0, 3'd0, 6'd0, 1'b0, 48'd0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 2'b00, 1'b0, 1'b1);
      add_vec(1'b0, 3'd0, 3'd0, 6'd0, 1'b0, 48'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 2'b00, 1'b0, 1'b0);
      add_vec(1'b0, 3'd0, 3'd0, 6'd0, 1'b0, 48'd0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 2'b00, 1'b0, 1'b1);
      add_vec(1'b0, 3'd0, 3'd0, 6'd0, 1'b0, 48'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 2'b00, 1'b0, 1'b0);
      // illegal lengths 0 and MAX_LEN+1
      add_vec(1'b1, 3'd1, 3'd1, 6'd0, 1'b0, 48'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 2'b00, 1'b1, 1'b0);
      add_vec(1'b0, 3'd0, 3'd0, 6'd0, 1'b0, 48'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 2'b00, 1'b0, 1'b0);
      add_vec(1'b1, 3'd1, 3'd1, 6'd17, 1'b0, 48'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 2'b00, 1'b1, 1'b0);
      add_vec(1'b0, 3'd0, 3'd0, 6'd0, 1'b0, 48'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 2'b00, 1'b0, 1'b0);

      foreach (vecs[i]) begin
         req_valid     = vecs[i].rv;
         req_dest_x    = vecs[i].dx;
         req_dest_y    = vecs[i].dy;
         req_len       = vecs[i].len;
         data_valid    = vecs[i].dv;
         data_in       = vecs[i].data;
         credit_return = vecs[i].cr;
         #1;
         chk1($sformatf("vec%0d_req_ready", i), req_ready, vecs[i].e_rr);
         chk1($sformatf("vec%0d_data_ready", i), data_ready, vecs[i].e_dr);
         chk1($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
         step();
         chk1($sformatf("vec%0d_flit_valid", i), flit_valid, vecs[i].e_fv);
         if (vecs[i].e_fv) begin
            chk64($sformatf("vec%0d_flit_out", i), flit_out, vecs[i].e_flit);
            chk64($sformatf("vec%0d_flit_vc", i), 64'(flit_vc), 64'(vecs[i].e_vc));
         end
         chk1($sformatf("vec%0d_err_len", i), err_len, vecs[i].e_el);
         chk1($sformatf("vec%0d_credit_err", i), credit_err, vecs[i].e_ce);
      end
      idle_inputs();

      // Credit stall: id 3 to (1,1) len 5, credits 4 on VC0, no returns
      curr_x = 3'd4;
      curr_y = 3'd6;
      exp_q.push_back(mk_flit(3'd1, 3'd1, 3'b000, 7'd3, mk_head_pl(3'd6, 3'd4, 6'd5)));
      for (int k = 1; k <= 4; k++) begin
         exp_q.push_back(mk_flit(3'd1, 3'd1, 3'b001, 7'd3, 48'h5700_0000_0000 + 48'(k)));
      end
      exp_q.push_back(mk_flit(3'd1, 3'd1, 3'b010, 7'd3, 48'h5700_0000_0005));
      chk64("stall_head_const", exp_q[0], 64'h2403_D050_0000_0000);
      req_valid  = 1'b1;
      req_dest_x = 3'd1;
      req_dest_y = 3'd1;
      req_len    = 6'd5;
      step();
      chk1("stall_req_no_flit", flit_valid, 1'b0);
      idle_inputs();
      step();
      chk_flit_q("stall_head");
      for (int k = 1; k <= 3; k++) begin
         data_valid = 1'b1;
         data_in    = 48'h5700_0000_0000 + 48'(k);
         #1;
         chk1("stall_body_ready", data_ready, 1'b1);
         step();
         chk_flit_q("stall_body");
      end
      data_in = 48'h5700_0000_0004;
      for (int k = 0; k < 2; k++) begin
         #1;
         chk1("stall_no_ready", data_ready, 1'b0);
         step();
         chk1("stall_no_flit", flit_valid, 1'b0);
      end
      credit_return = 2'b01;
      #1;
      chk1("stall_ret_cycle_ready", data_ready, 1'b0);
      step();
      chk1("stall_ret_cycle_flit", flit_valid, 1'b0);
      credit_return = 2'b00;
      #1;
      chk1("stall_after_ret_ready", data_ready, 1'b1);
      step();
      chk_flit_q("stall_resume_body");
      data_in       = 48'h5700_0000_0005;
      credit_return = 2'b01;
      #1;
      chk1("stall2_ready", data_ready, 1'b0);
      step();
      chk1("stall2_no_flit", flit_valid, 1'b0);
      credit_return = 2'b00;
      step();
      chk_flit_q("stall_tail");
      idle_inputs();
      chk64("stall_queue_empty", 64'(exp_q.size()), 64'd0);
      for (int k = 0; k < 4; k++) begin
         credit_return = 2'b01;
         step();
         chk1("stall_refill_no_err", credit_err, 1'b0);
      end
      idle_inputs();

      // Send and return on VC0 in the same cycle: id 4 to (0,0), len 1
      req_valid = 1'b1;
      req_len   = 6'd1;
      step();
      req_valid     = 1'b0;
      credit_return = 2'b01;
      step();
      chk64("same_cycle_head", flit_out, 64'h0004_D010_0000_0000);
      chk1("same_cycle_no_err", credit_err, 1'b0);
      credit_return = 2'b00;
      data_valid    = 1'b1;
      data_in       = 48'h0000_1234_5678;
      step();
      chk64("same_cycle_tail", flit_out, 64'h0104_0000_1234_5678);
      idle_inputs();
      credit_return = 2'b01;
      step();
      chk1("same_cycle_ret1_no_err", credit_err, 1'b0);
      step();
      chk1("same_cycle_ret2_err", credit_err, 1'b1);
      credit_return = 2'b00;
      step();
      chk1("same_cycle_err_clears", credit_err, 1'b0);

      // Packet ID wrap: ids 5..127, then the 128th packet reuses id 1
      for (int id = 5; id <= 127; id++) begin
         send_short(7'(id), 48'h00AB_0000_0000 + 48'(id));
      end
      send_short(7'd1, 48'h00CD_0000_0001);

      // Reset during DATA of packet id 2, len 3
      req_valid  = 1'b1;
      req_dest_x = 3'd2;
      req_dest_y = 3'd2;
      req_len    = 6'd3;
      step();
      idle_inputs();
      step();
      chk64("abort_head_id", 64'(flit_out[54:48]), 64'd2);
      data_valid = 1'b1;
      data_in    = 48'h0000_0000_0F01;
      step();
      chk1("abort_body_valid", flit_valid, 1'b1);
      data_in = 48'h0000_0000_0F02;
      rst     = 1'b1;
      step();
      chk1("abort_flit_valid", flit_valid, 1'b0);
      chk1("abort_req_ready", req_ready, 1'b1);
      chk1("abort_busy", busy, 1'b0);
      chk64("abort_flit_out", flit_out, 64'd0);
      rst = 1'b0;
      idle_inputs();

      // After reset: id back to 1 and 4 fresh VC0 credits carry a len-3 packet
      req_valid  = 1'b1;
      req_dest_x = 3'd7;
      req_dest_y = 3'd0;
      req_len    = 6'd3;
      step();
      idle_inputs();
      step();
      chk64("post_rst_head", flit_out,
            mk_flit(3'd0, 3'd7, 3'b000, 7'd1, mk_head_pl(3'd6, 3'd4, 6'd3)));
      for (int k = 1; k <= 3; k++) begin
         w          = 48'h7700_0000_0000 + 48'(k);
         data_valid = 1'b1;
         data_in    = w;
         #1;
         chk1("post_rst_ready", data_ready, 1'b1);
         step();
         chk64("post_rst_data", flit_out,
               mk_flit(3'd0, 3'd7, (k == 3) ? 3'b010 : 3'b001, 7'd1, w));
      end
      idle_inputs();
      step();
      chk1("post_rst_idle", req_ready, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ni_packetizer.md
Name: ni_packetizer

Overview:
- Network-interface transmitter between a PE and its router's local input port; produces the flit stream that the router's route-computation stage decodes.
- Accepts a message request (destination, length) plus a stream of 48-bit payload words.
- Emits a head flit, then body flits, then a tail flit in the NoC 64-bit flit format.
- Per-VC credit flow control: a flit is emitted only when the downstream VC buffer has space.

Parameters:
BUF_DEPTH, 4, router local input buffer depth per VC; reset/max credit count (1..15)
MAX_LEN, 16, max payload words per packet (1..63)
PKT_ID_START, 1, first packet ID after reset (1..127)

Ports:
clk  input  1  clock
rst  input  1  reset
curr_x  input  3  this node X (source coord)
curr_y  input  3  this node Y
req_valid  input  1  message request valid
req_ready  output  1  request accepted when valid&ready
req_dest_x  input  3  destination X
req_dest_y  input  3  destination Y
req_len  input  6  payload word count
data_valid  input  1  payload word valid
data_ready  output  1  payload word consumed when valid&ready
data_in  input  48  payload word
credit_return  input  2  per-VC one-cycle credit pulse from router
flit_out  output  64  flit
flit_valid  output  1  flit_out valid, one cycle per flit
flit_vc  output  2  VC of flit (00=VC0, 01=VC1)
busy  output  1  packet in progress
err_len  output  1  one-cycle pulse on illegal length
credit_err  output  1  one-cycle pulse on credit overflow

Behaviour:
- Reset is synchronous and active-high: rst sampled on posedge clk.
- Reset values: flit_out=0, flit_valid=0, flit_vc=0, err_len=0, credit_err=0, busy=0, state=IDLE, both credit counters=BUF_DEPTH, pkt_id=PKT_ID_START.
- rst asserted mid-packet aborts the packet immediately; no tail flit is sent.
- Flit format:
  - [63:61] dest_y, [60:58] dest_x.
  - [57:55] type: 000 head, 001 body, 010 tail.
  - [54:48] pkt_id.
  - [47:0] payload.
- Head payload: [47:45] curr_y, [44:42] curr_x, [41:36] len, [35:0] 0.
- Data flits: words 1..len-1 are body flits; word len is the tail flit. Total flits per packet = len+1.
- Registered outputs: flit_valid is high for exactly one cycle per flit. The router accepts every flit unconditionally; credits guarantee space.
- States: IDLE, HEAD, DATA.
  - IDLE: req_ready=1.
    - On accept with len in 1..MAX_LEN: latch dest and len, go to HEAD.
    - On accept with len=0 or len>MAX_LEN: pulse err_len next cycle, no flits, stay IDLE, pkt_id unchanged.
  - HEAD: select VC0 if credit0>0, else VC1 if credit1>0, else stall.
    - On selection: register head flit at this edge, lock the VC for the packet, go to DATA.
    - Head appears one cycle after request acceptance at the earliest.
  - DATA: data_ready = data_valid-independent (credit[vc]>0).
    - On valid&ready: register body/tail flit next edge.
    - After the tail: increment pkt_id, return to IDLE.
- Credit counters:
  - Next value = cnt - sent + returned. Simultaneous send and return leaves the count unchanged.
  - A return with cnt==BUF_DEPTH and no send saturates the counter and pulses credit_err.
- pkt_id wraps 127→1 and never takes value 0. A head with dest (0,0) then can never be all-zero, which the router treats as an empty slot.
- busy=1 in HEAD and DATA.
- Back-to-back packets: a new request is accepted in the cycle after the tail is registered.

Optional Feature:
PKTZ_STATS_EN
- When defined, adds the following, each cleared by rst:
  - Output pkt_sent_cnt[15:0]: incremented per tail flit, wraps.
  - Output stall_cnt[15:0]: incremented per cycle in HEAD/DATA with credit[vc]==0, saturates at 0xFFFF.
- When not defined, these ports and their logic are absent.

Test Plan:
1. Reset → flit_valid=0, req_ready=1, busy=0; 4 flits to VC0 with no credit returns all succeed.
2. curr=(0,0), req dest_x=2 dest_y=1 len=3, data A,B,C → flit_vc=00 and:
   - head 0x2801_0030_0000_0000;
   - body 0x2881_ then A;
   - body 0x2881_ then B;
   - tail 0x2901_ then C;
   - then pkt_id=2.
3. BUF_DEPTH=4, len=5, no returns → head + 3 bodies, then data_ready=0 stall. Single credit_return[0] pulse → next flit emitted 1 cycle later.
4. Credit0=0 at HEAD, credit1=4 → whole packet on flit_vc=01. credit_return=01 in the same cycle as a VC0 send → credit0 unchanged.
5. req_len=0, and req_len=MAX_LEN+1 → err_len pulses once each, no flit_valid. Return with full counter → credit_err pulse.
6. 127 packets from PKT_ID_START=1 → 128th packet's head has pkt_id=1. rst during DATA → flit_valid=0 next cycle, req_ready=1.
